// File: rtl/frame_serializer_if.sv
// frame_serializer_if: frame capture inputs, output beat stream and status for frame_serializer
//   frame_valid_i/frame_length_i/frame_data_i : parallel frame from the packet processor
//   out_valid_o/out_ready_i/out_data_o/out_last_o/out_index_o : serialized word stream
//   drop_count_o/buf_count_o : status
interface frame_serializer_if #(
    parameter int MAX_PACKETS      = 4,
    parameter int DATA_WIDTH_BYTES = 2
);
    localparam int DW = DATA_WIDTH_BYTES * 8;
    localparam int LW = $clog2(MAX_PACKETS) + 1;
    logic                      frame_valid_i;
    logic [LW-1:0]             frame_length_i;
    logic [MAX_PACKETS*DW-1:0] frame_data_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [DW-1:0]             out_data_o;
    logic                      out_last_o;
    logic [LW-1:0]             out_index_o;
    logic [7:0]                drop_count_o;
    logic [1:0]                buf_count_o;
    modport master (
        output frame_valid_i, frame_length_i, frame_data_i, out_ready_i,
        input  out_valid_o, out_data_o, out_last_o, out_index_o, drop_count_o, buf_count_o
    );
    modport slave (
        input  frame_valid_i, frame_length_i, frame_data_i, out_ready_i,
        output out_valid_o, out_data_o, out_last_o, out_index_o, drop_count_o, buf_count_o
    );
endinterface

// File: rtl/frame_serializer.sv
// frame_serializer: buffers up to two parallel frames and replays them word by word on a valid/ready stream
//   clk, rst : clock, asynchronous active-high reset
//   bus      : frame_serializer_if.slave (frame capture in, beat stream out, drop/buffer counters)
module frame_serializer #(
    parameter int MAX_PACKETS      = 4,
    parameter int DATA_WIDTH_BYTES = 2
) (
    input logic              clk,
    input logic              rst,
    frame_serializer_if.slave bus
);
    localparam int DW = DATA_WIDTH_BYTES * 8;
    localparam int LW = $clog2(MAX_PACKETS) + 1;
    localparam int FW = MAX_PACKETS * DW;

    typedef enum logic {S_EMPTY, S_STREAM} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q [2];
    logic [FW-1:0] data_q [2];
    logic          head_q, tail_q;
    logic [1:0]    count_q, count_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [7:0]    drop_q;
    logic [LW-1:0] head_len, cap_len;
    logic          hs, fin, cap, drop, wr;

    assign head_len = len_q[head_q];
    assign cap_len  = (bus.frame_length_i > LW'(MAX_PACKETS)) ? LW'(MAX_PACKETS) : bus.frame_length_i;

    // A head frame finishing in the same cycle frees its slot, so a full buffer
    // can still accept the arriving frame without dropping it.
    always_comb begin
        hs      = (state_q == S_STREAM) && bus.out_ready_i;
        fin     = hs && (beat_q == head_len - LW'(1));
        cap     = bus.frame_valid_i && (bus.frame_length_i != '0);
        drop    = cap && (count_q == 2'd2) && !fin;
        wr      = cap && !drop;
        beat_d  = fin ? '0 : hs ? beat_q + LW'(1) : beat_q;
        count_d = count_q + {1'b0, wr} - {1'b0, fin};
        state_d = (count_d == 2'd0) ? S_EMPTY : S_STREAM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            beat_q  <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
            if (fin)
                head_q <= ~head_q;
            if (wr)
                tail_q <= ~tail_q;
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

    // Frame storage needs no reset: it is only observed while its slot is occupied.
    always_ff @(posedge clk) begin
        if (wr) begin
            len_q[tail_q]  <= cap_len;
            data_q[tail_q] <= bus.frame_data_i;
        end
    end

    assign bus.out_valid_o  = (state_q == S_STREAM);
    assign bus.out_data_o   = bus.out_valid_o ? data_q[head_q][beat_q*DW +: DW] : '0;
    assign bus.out_last_o   = bus.out_valid_o && (beat_q == head_len - LW'(1));
    assign bus.out_index_o  = beat_q;
    assign bus.drop_count_o = drop_q;
    assign bus.buf_count_o  = count_q;
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: randomized and directed checks of frame_serializer against a beat-queue reference model
module tb_frame_serializer;
    localparam int MP = 4;
    localparam int DW = 16;
    localparam int LW = 3;
    localparam int OW = 1 + DW + 1 + LW + 2 + 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [LW-1:0] i;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_serializer_if #(.MAX_PACKETS(MP), .DATA_WIDTH_BYTES(2)) bus ();
    frame_serializer #(.MAX_PACKETS(MP), .DATA_WIDTH_BYTES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Model: every word still to be emitted, in order; a frame is held while its last word is queued.
    beat_t exp_q[$];
    int    m_drop;
    int    cmp_n  = 0;
    int    fail_n = 0;

    function automatic int m_frames();
        int n = 0;
        foreach (exp_q[k]) if (exp_q[k].l) n++;
        return n;
    endfunction

    function automatic logic [OW-1:0] expv();
        if (exp_q.size() == 0)
            return {1'b0, {DW{1'b0}}, 1'b0, {LW{1'b0}}, 2'd0, 8'(m_drop)};
        return {1'b1, exp_q[0].d, exp_q[0].l, exp_q[0].i, 2'(m_frames()), 8'(m_drop)};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.out_valid_o, bus.out_data_o, bus.out_last_o, bus.out_index_o,
                bus.buf_count_o, bus.drop_count_o};
    endfunction

    task automatic drive(input bit fv, input int len, input logic [MP*DW-1:0] d, input bit rdy);
        bus.frame_valid_i  = fv;
        bus.frame_length_i = LW'(len);
        bus.frame_data_i   = d;
        bus.out_ready_i    = rdy;
    endtask

    task automatic tick();
        bit hs, fin, cap, drop;
        int n, len;
        n    = m_frames();
        hs   = (exp_q.size() != 0) && bus.out_ready_i;
        fin  = hs && exp_q[0].l;
        cap  = bus.frame_valid_i && (bus.frame_length_i != 0);
        drop = cap && (n == 2) && !fin;
        if (hs) void'(exp_q.pop_front());
        if (cap && !drop) begin
            len = (int'(bus.frame_length_i) > MP) ? MP : int'(bus.frame_length_i);
            for (int i = 0; i < len; i++)
                exp_q.push_back('{bus.frame_data_i[i*DW +: DW], i == len - 1, LW'(i)});
        end
        if (drop && m_drop < 255) m_drop++;
        @(posedge clk);
        #1;
        bus.frame_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, '0, 0);
        exp_q.delete();
        m_drop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, '0, 0);
        exp_q.delete();
        m_drop = 0;
        #1;
        cmp_n++; if (obs() !== '0) begin fail_n++; $display("FAIL reset_async: got %h want 0", obs()); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_n++; if (obs() !== '0) begin fail_n++; $display("FAIL reset_release: got %h want 0", obs()); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(1, 3, {16'h0000, 16'h3333, 16'h2222, 16'h1111}, 1);
        cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL basic_cap: got %h want %h", obs(), expv()); end
        tick();
        cmp_n++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 16'h1111) begin fail_n++; $display("FAIL basic_latency: got v=%b d=%h want v=1 d=1111", bus.out_valid_o, bus.out_data_o); end
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, '0, 1);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL basic c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        cmp_n++; if (bus.out_valid_o !== 1'b0 || bus.buf_count_o !== 2'd0) begin fail_n++; $display("FAIL basic_idle: got v=%b buf=%0d want v=0 buf=0", bus.out_valid_o, bus.buf_count_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, 2, {32'h0, 16'hBBBB, 16'hAAAA}, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, '0, 0);
            cmp_n++; if (obs() !== expv() || bus.out_data_o !== 16'hAAAA || bus.out_index_o !== 3'd0) begin fail_n++; $display("FAIL stall c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, '0, 1);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL stall_release c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
    endtask

    task automatic test_overflow();
        int beats = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 4, {$urandom, $urandom}, 0);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL ovf_fill c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        cmp_n++; if (bus.buf_count_o !== 2'd2 || bus.drop_count_o !== 8'd1) begin fail_n++; $display("FAIL ovf_counts: got buf=%0d drop=%0d want buf=2 drop=1", bus.buf_count_o, bus.drop_count_o); end
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, '0, 1);
            if (bus.out_valid_o) beats++;
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL ovf_drain c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        cmp_n++; if (beats != 8) begin fail_n++; $display("FAIL ovf_beats: got %0d want 8", beats); end
    endtask

    task automatic test_simul();
        bit sent = 0;
        do_reset();
        drive(1, 2, {$urandom, $urandom}, 0);
        tick();
        drive(1, 3, {$urandom, $urandom}, 0);
        tick();
        for (int c = 0; c < 14; c++) begin
            drive(0, 0, '0, 1);
            if (!sent && exp_q.size() != 0 && exp_q[0].l && m_frames() == 2) begin
                drive(1, 4, {$urandom, $urandom}, 1);
                sent = 1;
                cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL simul_pre: got %h want %h", obs(), expv()); end
                tick();
                cmp_n++; if (bus.buf_count_o !== 2'd2 || bus.drop_count_o !== 8'd0) begin fail_n++; $display("FAIL simul_counts: got buf=%0d drop=%0d want buf=2 drop=0", bus.buf_count_o, bus.drop_count_o); end
            end else begin
                cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL simul c%0d: got %h want %h", c, obs(), expv()); end
                tick();
            end
        end
        cmp_n++; if (!sent || bus.out_valid_o !== 1'b0) begin fail_n++; $display("FAIL simul_done: got sent=%0d v=%b want sent=1 v=0", sent, bus.out_valid_o); end
    endtask

    task automatic test_edges();
        int beats = 0;
        do_reset();
        drive(1, 0, {$urandom, $urandom}, 1);
        tick();
        for (int c = 0; c < 2; c++) begin
            cmp_n++; if (obs() !== '0) begin fail_n++; $display("FAIL len0 c%0d: got %h want 0", c, obs()); end
            tick();
        end
        drive(1, 7, {$urandom, $urandom}, 1);
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, '0, 1);
            if (bus.out_valid_o) beats++;
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL len7 c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        cmp_n++; if (beats != 4) begin fail_n++; $display("FAIL len7_beats: got %0d want 4", beats); end
        drive(1, 1, {48'h0, 16'h5A5A}, 1);
        tick();
        drive(0, 0, '0, 1);
        cmp_n++; if (bus.out_valid_o !== 1'b1 || bus.out_last_o !== 1'b1 || bus.out_data_o !== 16'h5A5A) begin fail_n++; $display("FAIL len1: got v=%b l=%b d=%h want v=1 l=1 d=5a5a", bus.out_valid_o, bus.out_last_o, bus.out_data_o); end
        tick();
        cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL len1_after: got %h want %h", obs(), expv()); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 262; c++) begin
            drive(1, 1 + ($urandom % 4), {$urandom, $urandom}, 0);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL sat c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        cmp_n++; if (bus.drop_count_o !== 8'd255) begin fail_n++; $display("FAIL sat_final: got %0d want 255", bus.drop_count_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 4, {$urandom, $urandom}, 1);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, '0, 1);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL arst_pre c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        cmp_n++; if (obs() !== '0) begin fail_n++; $display("FAIL arst_now: got %h want 0", obs()); end
        exp_q.delete();
        m_drop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, '0, 1);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL arst_idle c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
        drive(1, 2, {$urandom, $urandom}, 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, '0, 1);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL arst_new c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            drive(($urandom % 3) == 0, $urandom % 8, {$urandom, $urandom}, ($urandom % 4) != 0);
            cmp_n++; if (obs() !== expv()) begin fail_n++; $display("FAIL rand c%0d: got %h want %h", c, obs(), expv()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_simul();
        test_edges();
        test_saturate();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
